// File: rtl/eeprom_ctrl.sv
// Host-side sequencer for an AT28C256-style parallel EEPROM: single-beat reads,
// and writes followed by bit-7 DATA polling until completion or a poll limit.
module eeprom_ctrl #(
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 2,
  parameter int POLL_MAX  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [14:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [14:0] a,
  output logic        ce,
  output logic        oe,
  output logic        we,
  inout  wire  [7:0]  io
);

  localparam int WMAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int WCW  = $clog2(WMAX) + 1;
  localparam int PCW  = $clog2(POLL_MAX) + 1;
  localparam logic [WCW-1:0] RD_LAST   = WCW'(RD_CYCLES - 1);
  localparam logic [WCW-1:0] WE_LAST   = WCW'(WE_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_SAT  = '1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WS, S_WP, S_WH, S_TA, S_PL, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [PCW-1:0] poll_cnt;
  logic [7:0]     wdata_q;
  logic           accept, sample, poll_restart, wait_clr, drive;

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    sample       = 1'b0;
    poll_restart = 1'b0;
    case (state)
      S_IDLE: if (req_valid) begin
        accept    = 1'b1;
        state_nxt = req_we ? S_WS : S_RD;
      end
      S_RD: if (wait_cnt == RD_LAST) begin
        sample    = 1'b1;
        state_nxt = S_DONE;
      end
      S_WS: state_nxt = S_WP;
      S_WP: if (wait_cnt == WE_LAST) state_nxt = S_WH;
      S_WH: state_nxt = S_TA;
      S_TA: state_nxt = S_PL;
      // Consecutive polls keep oe low; only the wait counter restarts.
      S_PL: if (wait_cnt == RD_LAST) begin
        sample = 1'b1;
        if (io[7] == wdata_q[7] || poll_cnt == POLL_LAST) state_nxt = S_DONE;
        else poll_restart = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wait_clr = (state_nxt != state) || poll_restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      poll_cnt  <= '0;
      a         <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wait_clr) wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
      if (state_nxt == S_PL && state != S_PL) poll_cnt <= '0;
      else if (poll_restart) poll_cnt <= poll_cnt + 1'b1;
      if (accept) begin
        a       <= req_addr;
        rsp_err <= 1'b0;
      end
      if (sample) rsp_rdata <= io;
      if (state == S_PL && state_nxt == S_DONE) rsp_err <= (io[7] != wdata_q[7]);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req_wdata;
  end

  // Pins decode straight from state so reset releases the bus asynchronously.
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign ce        = (state == S_IDLE) || (state == S_DONE);
  assign oe        = !((state == S_RD) || (state == S_PL));
  assign we        = (state != S_WP);
  assign drive     = (state == S_WS) || (state == S_WP) || (state == S_WH);
  assign io        = drive ? wdata_q : 8'bz;

endmodule
